// File: rtl/lcd_ctrl_if.sv
// Write-request channel into the LCD controller: byte plus register-select
// with a valid/ready handshake.
interface lcd_ctrl_if;
    logic       wr_valid;
    logic       wr_ready;
    logic       wr_rs;
    logic [7:0] wr_data;

    modport master (output wr_valid, output wr_rs, output wr_data, input wr_ready);
    modport slave  (input wr_valid, input wr_rs, input wr_data, output wr_ready);
endinterface

// File: rtl/lcd_ctrl.sv
// HD44780-style LCD write controller: request FIFO plus setup/enable/hold/wait
// sequencer. Define LCD_INIT_EN to run the power-up init sequence after reset.
//
// state | meaning
// PWRUP | power-up delay before init commands (LCD_INIT_EN only)
// IDLE  | waiting for a queued request or pending init command
// SETUP | RS/DATA stable, EN low
// PULSE | EN high
// HOLD  | EN low, RS/DATA held
// WAIT  | LCD execution time (long for clear/home)
module lcd_ctrl #(
    parameter int SETUP_CYC    = 2,
    parameter int EN_CYC       = 12,
    parameter int HOLD_CYC     = 2,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000,
    parameter int PWRUP_CYC    = 750000,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    lcd_ctrl_if.slave   wr,
    input  logic        i_lcd_on,
    output logic        o_busy,
    output logic        o_init_done,
    output logic        o_lcd_on,
    output logic        o_lcd_en,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic [7:0]  o_lcd_data
);

    localparam int MAX_A   = (SETUP_CYC > EN_CYC) ? SETUP_CYC : EN_CYC;
    localparam int MAX_B   = (HOLD_CYC > CMD_WAIT_CYC) ? HOLD_CYC : CMD_WAIT_CYC;
    localparam int MAX_C   = (CLR_WAIT_CYC > PWRUP_CYC) ? CLR_WAIT_CYC : PWRUP_CYC;
    localparam int MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] EN_LD    = CNT_W'(EN_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_PWRUP, S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [8:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     fifo_cnt;
    logic               fifo_empty;
    logic               push, pop, load_init;
    logic               init_pending;
    logic [7:0]         init_cmd;
    logic               is_clr;

    assign fifo_empty  = (fifo_cnt == '0);
    assign wr.wr_ready = (fifo_cnt != FULL_CNT);
    assign push        = wr.wr_valid && wr.wr_ready;
    // Init commands take priority so user requests queued during init wait their turn.
    assign load_init   = (state == S_IDLE) && init_pending;
    assign pop         = (state == S_IDLE) && !init_pending && !fifo_empty;
    assign is_clr      = !o_lcd_rs && ((o_lcd_data == 8'h01) || (o_lcd_data == 8'h02));

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_CYC - 1);
    localparam state_t RST_STATE = S_PWRUP;

    logic [2:0] init_idx;
    logic       init_done;

    assign init_pending = (init_idx != 3'd4);
    assign o_init_done  = init_done;

    always_comb begin
        case (init_idx)
            3'd0:    init_cmd = 8'h38;
            3'd1:    init_cmd = 8'h0C;
            3'd2:    init_cmd = 8'h01;
            default: init_cmd = 8'h06;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            init_idx  <= 3'd0;
            init_done <= 1'b0;
        end else begin
            if (load_init)
                init_idx <= init_idx + 3'd1;
            if ((state == S_WAIT) && (state_nxt == S_IDLE) && !init_pending)
                init_done <= 1'b1;
        end
    end
`else
    localparam state_t RST_STATE = S_IDLE;

    assign init_pending = 1'b0;
    assign init_cmd     = 8'h00;
    assign o_init_done  = 1'b1;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= RST_STATE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
`ifdef LCD_INIT_EN
            S_PWRUP: if (cnt == PWRUP_LD) state_nxt = S_IDLE;
`endif
            S_IDLE:  if (load_init || pop) state_nxt = S_SETUP;
            S_SETUP: if (cnt == '0) state_nxt = S_PULSE;
            S_PULSE: if (cnt == '0) state_nxt = S_HOLD;
            S_HOLD:  if (cnt == '0) state_nxt = S_WAIT;
            S_WAIT:  if (cnt == '0) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        o_lcd_en = (state == S_PULSE);
        o_lcd_rw = 1'b0;
        o_busy   = (state != S_IDLE) || !fifo_empty || init_pending;
    end

    // Down-counter reloaded on every state change; PWRUP alone counts up from the reset value.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt <= '0;
        end else if (state_nxt != state) begin
            case (state_nxt)
                S_SETUP: cnt <= SETUP_LD;
                S_PULSE: cnt <= EN_LD;
                S_HOLD:  cnt <= HOLD_LD;
                S_WAIT:  cnt <= is_clr ? CLR_LD : CMD_LD;
                default: cnt <= '0;
            endcase
        end else if (state == S_PWRUP) begin
            cnt <= cnt + CNT_W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push)
            mem[wr_ptr] <= {wr.wr_rs, wr.wr_data};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= 8'h00;
            o_lcd_on   <= 1'b0;
        end else begin
            o_lcd_on <= i_lcd_on;
            if (pop) begin
                o_lcd_rs   <= mem[rd_ptr][8];
                o_lcd_data <= mem[rd_ptr][7:0];
            end else if (load_init) begin
                o_lcd_rs   <= 1'b0;
                o_lcd_data <= init_cmd;
            end
        end
    end

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed self-checking bench for lcd_ctrl with short timing parameters.
// Build with LCD_INIT_EN defined to exercise the power-up init sequence.
module tb_lcd_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst_n;
    logic       i_lcd_on;
    logic       o_busy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic       en_q = 1'b0;
    logic [8:0] em_q[$];
    int         em_t[$];

    lcd_ctrl_if wr_if ();

    lcd_ctrl #(
        .SETUP_CYC(2), .EN_CYC(4), .HOLD_CYC(2), .CMD_WAIT_CYC(8),
        .CLR_WAIT_CYC(20), .PWRUP_CYC(10), .FIFO_DEPTH(4)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .wr(wr_if.slave), .i_lcd_on(i_lcd_on),
        .o_busy(o_busy), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
        .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw),
        .o_lcd_data(o_lcd_data)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) cyc <= cyc + 1;

    // Log every EN rising edge with the bus contents and cycle number.
    always @(posedge i_clk) begin
        #1;
        if (o_lcd_en && !en_q) begin
            em_q.push_back({o_lcd_rs, o_lcd_data});
            em_t.push_back(cyc);
        end
        en_q = o_lcd_en;
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst_n         = 1'b0;
        i_lcd_on        = 1'b1;
        wr_if.wr_valid  = 1'b0;
        wr_if.wr_rs     = 1'b0;
        wr_if.wr_data   = 8'h00;
        repeat (3) tick();
        checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL rst_en: got %b want 0", o_lcd_en); end
        checks++; if (o_lcd_rs !== 1'b0) begin errors++; $display("FAIL rst_rs: got %b want 0", o_lcd_rs); end
        checks++; if (o_lcd_data !== 8'h00) begin errors++; $display("FAIL rst_data: got %h want 00", o_lcd_data); end
        checks++; if (o_lcd_on !== 1'b0) begin errors++; $display("FAIL rst_on: got %b want 0", o_lcd_on); end
        checks++; if (o_lcd_rw !== 1'b0) begin errors++; $display("FAIL rst_rw: got %b want 0", o_lcd_rw); end
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", wr_if.wr_ready); end
`ifdef LCD_INIT_EN
        checks++; if (o_init_done !== 1'b0) begin errors++; $display("FAIL rst_init_done: got %b want 0", o_init_done); end
`else
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", o_busy); end
        checks++; if (o_init_done !== 1'b1) begin errors++; $display("FAIL rst_init_done: got %b want 1", o_init_done); end
`endif
        i_lcd_on = 1'b0;
        i_rst_n  = 1'b1;
        tick();
    endtask

    task automatic test_lcd_on();
        i_lcd_on = 1'b1;
        #1;
        checks++; if (o_lcd_on !== 1'b0) begin errors++; $display("FAIL lcd_on_pre: got %b want 0", o_lcd_on); end
        tick();
        checks++; if (o_lcd_on !== 1'b1) begin errors++; $display("FAIL lcd_on_set: got %b want 1", o_lcd_on); end
        i_lcd_on = 1'b0;
        tick();
        checks++; if (o_lcd_on !== 1'b0) begin errors++; $display("FAIL lcd_on_clr: got %b want 0", o_lcd_on); end
    endtask

    task automatic test_data_write();
        em_q.delete(); em_t.delete();
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h41;
        tick();                                           // edge 0
        wr_if.wr_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dw_busy_e0: got %b want 1", o_busy); end
        tick();                                           // edge 1
        checks++; if ({o_lcd_rs, o_lcd_data} !== 9'h141) begin errors++; $display("FAIL dw_bus_e1: got %h want 141", {o_lcd_rs, o_lcd_data}); end
        tick();                                           // edge 2
        checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL dw_en_e2: got %b want 0", o_lcd_en); end
        tick();                                           // edge 3
        checks++; if (o_lcd_en !== 1'b1) begin errors++; $display("FAIL dw_en_e3: got %b want 1", o_lcd_en); end
        repeat (3) tick();                                // edge 6
        checks++; if (o_lcd_en !== 1'b1) begin errors++; $display("FAIL dw_en_e6: got %b want 1", o_lcd_en); end
        tick();                                           // edge 7
        checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL dw_en_e7: got %b want 0", o_lcd_en); end
        repeat (9) tick();                                // edge 16
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL dw_busy_e16: got %b want 1", o_busy); end
        tick();                                           // edge 17
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL dw_busy_e17: got %b want 0", o_busy); end
        checks++; if ({o_lcd_rs, o_lcd_data} !== 9'h141) begin errors++; $display("FAIL dw_bus_held: got %h want 141", {o_lcd_rs, o_lcd_data}); end
        checks++; if (em_q.size() !== 1) begin errors++; $display("FAIL dw_pulses: got %0d want 1", em_q.size()); end
    endtask

    task automatic test_clear_wait();
        em_q.delete(); em_t.delete();
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b0; wr_if.wr_data = 8'h01;
        tick();                                           // edge 0
        wr_if.wr_valid = 1'b0;
        repeat (3) tick();                                // edge 3
        checks++; if (o_lcd_en !== 1'b1) begin errors++; $display("FAIL clr_en_e3: got %b want 1", o_lcd_en); end
        checks++; if ({o_lcd_rs, o_lcd_data} !== 9'h001) begin errors++; $display("FAIL clr_bus: got %h want 001", {o_lcd_rs, o_lcd_data}); end
        repeat (4) tick();                                // edge 7
        checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL clr_en_e7: got %b want 0", o_lcd_en); end
        repeat (21) tick();                               // edge 28
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL clr_busy_e28: got %b want 1", o_busy); end
        tick();                                           // edge 29
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL clr_busy_e29: got %b want 0", o_busy); end
    endtask

    task automatic test_back_to_back();
        int   acc_e[6];
        int   idx = 0;
        int   e = 0;
        int   w = 0;
        logic r;
        em_q.delete(); em_t.delete();
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h30;
        while (idx < 6 && e < 200) begin
            r = wr_if.wr_ready;
            tick();
            if (r) begin
                acc_e[idx] = e;
                idx++;
                if (idx < 6) wr_if.wr_data = 8'h30 + 8'(idx);
                else wr_if.wr_valid = 1'b0;
            end
            e++;
        end
        wr_if.wr_valid = 1'b0;
        checks++; if (idx !== 6) begin errors++; $display("FAIL b2b_accepted: got %0d want 6", idx); end
        if (idx == 6) begin
            checks++; if (acc_e[4] !== 4) begin errors++; $display("FAIL b2b_fifth_edge: got %0d want 4", acc_e[4]); end
            checks++; if (acc_e[5] !== 19) begin errors++; $display("FAIL b2b_sixth_edge: got %0d want 19", acc_e[5]); end
        end
        while (o_busy && w < 300) begin tick(); w++; end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_drain: busy still %b after %0d cycles", o_busy, w); end
        checks++; if (em_q.size() !== 6) begin errors++; $display("FAIL b2b_count: got %0d want 6", em_q.size()); end
        for (int i = 0; i < 6 && i < em_q.size(); i++) begin
            checks++; if (em_q[i] !== (9'h130 + 9'(i))) begin errors++; $display("FAIL b2b_order[%0d]: got %h want %h", i, em_q[i], 9'h130 + 9'(i)); end
            if (i > 0) begin
                checks++; if ((em_t[i] - em_t[i-1]) !== 17) begin errors++; $display("FAIL b2b_period[%0d]: got %0d want 17", i, em_t[i] - em_t[i-1]); end
            end
        end
    endtask

    task automatic test_reset_mid_pulse();
        int w = 0;
        int n0;
        em_q.delete(); em_t.delete();
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_if.wr_data = 8'h50 + 8'(i);
            tick();
        end
        wr_if.wr_valid = 1'b0;
        while (!o_lcd_en && w < 50) begin tick(); w++; end
        checks++; if (o_lcd_en !== 1'b1) begin errors++; $display("FAIL rmp_pulse_seen: got %b want 1", o_lcd_en); end
        #2 i_rst_n = 1'b0;
        #1;
        checks++; if (o_lcd_en !== 1'b0) begin errors++; $display("FAIL rmp_en_drop: got %b want 0", o_lcd_en); end
        checks++; if (wr_if.wr_ready !== 1'b1) begin errors++; $display("FAIL rmp_ready: got %b want 1", wr_if.wr_ready); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmp_busy: got %b want 0", o_busy); end
        checks++; if (o_lcd_data !== 8'h00) begin errors++; $display("FAIL rmp_data: got %h want 00", o_lcd_data); end
        repeat (2) tick();
        i_rst_n = 1'b1;
        n0 = em_q.size();
        repeat (80) tick();
        checks++; if (em_q.size() !== n0) begin errors++; $display("FAIL rmp_no_emit: got %0d pulses want %0d", em_q.size(), n0); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmp_idle: busy got %b want 0", o_busy); end
    endtask

`ifdef LCD_INIT_EN
    task automatic test_init();
        logic [8:0] exp_seq[5] = '{9'h038, 9'h00C, 9'h001, 9'h006, 9'h148};
        int w = 0;
        em_q.delete(); em_t.delete();
        tick();
        wr_if.wr_valid = 1'b1; wr_if.wr_rs = 1'b1; wr_if.wr_data = 8'h48;
        tick();
        wr_if.wr_valid = 1'b0;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL init_busy: got %b want 1", o_busy); end
        while (!o_init_done && w < 400) begin tick(); w++; end
        checks++; if (o_init_done !== 1'b1) begin errors++; $display("FAIL init_done: got %b want 1", o_init_done); end
        checks++; if (em_q.size() !== 4) begin errors++; $display("FAIL init_count_at_done: got %0d want 4", em_q.size()); end
        w = 0;
        while (o_busy && w < 200) begin tick(); w++; end
        checks++; if (em_q.size() !== 5) begin errors++; $display("FAIL init_total: got %0d want 5", em_q.size()); end
        for (int i = 0; i < 5 && i < em_q.size(); i++) begin
            checks++; if (em_q[i] !== exp_seq[i]) begin errors++; $display("FAIL init_seq[%0d]: got %h want %h", i, em_q[i], exp_seq[i]); end
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef LCD_INIT_EN
        test_init();
`else
        test_lcd_on();
        test_data_write();
        test_clear_wait();
        test_back_to_back();
        test_reset_mid_pulse();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
